// File: rtl/mipi_link_seq_if.sv
// Signal bundle between the MIPI link sequencer and the Rx/Tx PHY and controller pair.
// master = Rx/Tx side driving status and requests, slave = the sequencer.
interface mipi_link_seq_if;
   logic        rx_vsync;
   logic        rx_err;
   logic        retry_req;
   logic        rx_dphy_rstn;
   logic        rx_rstn;
   logic        tx_dphy_rstn;
   logic        tx_rstn;
   logic        rx_clear;
   logic        link_up;
   logic        link_fail;
   logic [3:0]  retry_cnt;
   logic [15:0] frame_cnt;
   logic [2:0]  state;
   logic [3:0]  tx_ulps_enter;
   logic [3:0]  tx_ulps_exit;

   modport master (
      output rx_vsync, rx_err, retry_req,
      input  rx_dphy_rstn, rx_rstn, tx_dphy_rstn, tx_rstn, rx_clear, link_up, link_fail,
             retry_cnt, frame_cnt, state, tx_ulps_enter, tx_ulps_exit
   );

   modport slave (
      input  rx_vsync, rx_err, retry_req,
      output rx_dphy_rstn, rx_rstn, tx_dphy_rstn, tx_rstn, rx_clear, link_up, link_fail,
             retry_cnt, frame_cnt, state, tx_ulps_enter, tx_ulps_exit
   );
endinterface

// File: rtl/mipi_link_seq.sv
// MIPI link bring-up/recovery sequencer: orders Tx/Rx PHY and controller resets, watches
// Rx frame starts, retries on faults. Define MIPI_LINK_SEQ_ULPS_EN for Tx ULPS on failure.
//
// state     | meaning
// RST_HOLD  | all four resets low for RST_CYCLES
// TX_UP     | Tx D-PHY released, Tx controller held 16 cycles
// RX_UP     | Tx controller and Rx D-PHY released, Rx controller held 16 cycles
// WAIT_SOF  | all released, waiting for the first frame start
// LINK      | frames arriving inside the watchdog window
// RECOVER   | Rx side in reset with rx_clear asserted for CLEAR_CYCLES
// FAIL      | retries exhausted, Rx side held in reset
// ULPS_EXIT | Tx lanes leaving ULPS for 16 cycles before full restart
module mipi_link_seq #(
   parameter int unsigned RST_CYCLES   = 1024,
   parameter int unsigned CLEAR_CYCLES = 16,
   parameter int unsigned WDT_CYCLES   = 4000000,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic           sys_clk,
   input  logic           i_arstn,
   mipi_link_seq_if.slave bus
);
   typedef enum logic [2:0] {
      RST_HOLD  = 3'd0,
      TX_UP     = 3'd1,
      RX_UP     = 3'd2,
      WAIT_SOF  = 3'd3,
      LINK      = 3'd4,
      RECOVER   = 3'd5,
      FAIL      = 3'd6,
      ULPS_EXIT = 3'd7
   } state_t;

   localparam int unsigned TMR_MAX = (RST_CYCLES > CLEAR_CYCLES) ?
                                     ((RST_CYCLES > 16) ? RST_CYCLES : 16) :
                                     ((CLEAR_CYCLES > 16) ? CLEAR_CYCLES : 16);
   localparam int TMR_W = $clog2(TMR_MAX + 1);
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);
   localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] CLEAR_LOAD = TMR_W'(CLEAR_CYCLES - 1);
   localparam logic [TMR_W-1:0] STEP_LOAD  = TMR_W'(15);
   localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
   localparam logic [WDT_W-1:0] WDT_LOAD   = WDT_W'(WDT_CYCLES - 1);
   localparam logic [WDT_W-1:0] WDT_ONE    = WDT_W'(1);
   localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

   logic [1:0]       rst_sync;
   logic             rst_n;
   logic [1:0]       vsync_sync;
   logic [1:0]       err_sync;
   logic             vsync_d;
   logic             sof;
   logic             err;
   logic             fault;
   logic             hold_req;

   state_t           state_q;
   logic [TMR_W-1:0] tmr;
   logic [WDT_W-1:0] wdt;
   logic [5:0]       sof_run;
   logic             rx_dphy_rstn_q;
   logic             rx_rstn_q;
   logic             tx_dphy_rstn_q;
   logic             tx_rstn_q;
   logic             rx_clear_q;
   logic             link_up_q;
   logic             link_fail_q;
   logic [3:0]       retry_q;
   logic [15:0]      frame_q;

   // Assertion is immediate, release waits two sys_clk edges.
   always_ff @(posedge sys_clk or negedge i_arstn) begin
      if (!i_arstn) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_sync <= 2'b00;
         err_sync   <= 2'b00;
         vsync_d    <= 1'b0;
      end else begin
         vsync_sync <= {vsync_sync[0], bus.rx_vsync};
         err_sync   <= {err_sync[0], bus.rx_err};
         vsync_d    <= vsync_sync[1];
      end
   end

   assign sof   = vsync_sync[1] & ~vsync_d;
   assign err   = err_sync[1];
   // A frame start in the expiry cycle still counts; an Rx error always wins.
   assign fault = err | ((wdt == '0) & ~sof);

   always_comb begin
      hold_req = 1'b0;
      case (state_q)
         LINK:      hold_req = bus.retry_req;
`ifdef MIPI_LINK_SEQ_ULPS_EN
         ULPS_EXIT: hold_req = (tmr == '0);
`else
         FAIL:      hold_req = bus.retry_req;
         ULPS_EXIT: hold_req = 1'b1;
`endif
         default:   hold_req = 1'b0;
      endcase
   end

`ifdef MIPI_LINK_SEQ_ULPS_EN
   logic [3:0] ulps_enter_q;
   logic [3:0] ulps_exit_q;
`endif

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RST_HOLD;
         tmr            <= RST_LOAD;
         wdt            <= WDT_LOAD;
         sof_run        <= '0;
         rx_dphy_rstn_q <= 1'b0;
         rx_rstn_q      <= 1'b0;
         tx_dphy_rstn_q <= 1'b0;
         tx_rstn_q      <= 1'b0;
         rx_clear_q     <= 1'b0;
         link_up_q      <= 1'b0;
         link_fail_q    <= 1'b0;
         retry_q        <= '0;
         frame_q        <= '0;
`ifdef MIPI_LINK_SEQ_ULPS_EN
         ulps_enter_q   <= '0;
         ulps_exit_q    <= '0;
`endif
      end else if (hold_req) begin
         state_q        <= RST_HOLD;
         tmr            <= RST_LOAD;
         wdt            <= WDT_LOAD;
         sof_run        <= '0;
         rx_dphy_rstn_q <= 1'b0;
         rx_rstn_q      <= 1'b0;
         tx_dphy_rstn_q <= 1'b0;
         tx_rstn_q      <= 1'b0;
         rx_clear_q     <= 1'b0;
         link_up_q      <= 1'b0;
         link_fail_q    <= 1'b0;
         retry_q        <= '0;
         frame_q        <= '0;
`ifdef MIPI_LINK_SEQ_ULPS_EN
         ulps_enter_q   <= '0;
         ulps_exit_q    <= '0;
`endif
      end else begin
         case (state_q)
            RST_HOLD: begin
               if (tmr == '0) begin
                  state_q        <= TX_UP;
                  tx_dphy_rstn_q <= 1'b1;
                  tmr            <= STEP_LOAD;
               end else tmr <= tmr - TMR_ONE;
            end
            TX_UP: begin
               if (tmr == '0) begin
                  state_q        <= RX_UP;
                  tx_rstn_q      <= 1'b1;
                  rx_dphy_rstn_q <= 1'b1;
                  tmr            <= STEP_LOAD;
               end else tmr <= tmr - TMR_ONE;
            end
            RX_UP: begin
               if (tmr == '0) begin
                  state_q   <= WAIT_SOF;
                  rx_rstn_q <= 1'b1;
                  wdt       <= WDT_LOAD;
               end else tmr <= tmr - TMR_ONE;
            end
            WAIT_SOF, LINK: begin
               if (fault) begin
                  link_up_q      <= 1'b0;
                  rx_dphy_rstn_q <= 1'b0;
                  rx_rstn_q      <= 1'b0;
                  if (retry_q == RETRY_MAX) begin
                     state_q     <= FAIL;
                     link_fail_q <= 1'b1;
`ifdef MIPI_LINK_SEQ_ULPS_EN
                     ulps_enter_q <= 4'hF;
`endif
                  end else begin
                     state_q    <= RECOVER;
                     retry_q    <= retry_q + 4'd1;
                     rx_clear_q <= 1'b1;
                     tmr        <= CLEAR_LOAD;
                  end
               end else if (sof) begin
                  state_q   <= LINK;
                  link_up_q <= 1'b1;
                  frame_q   <= frame_q + 16'd1;
                  wdt       <= WDT_LOAD;
                  // Only frames that arrive while already in LINK count toward the clean run.
                  if (state_q == WAIT_SOF) sof_run <= '0;
                  else if (sof_run == 6'd63) begin
                     sof_run <= '0;
                     retry_q <= '0;
                  end else sof_run <= sof_run + 6'd1;
               end else wdt <= wdt - WDT_ONE;
            end
            RECOVER: begin
               if (tmr == '0) begin
                  state_q        <= RX_UP;
                  rx_clear_q     <= 1'b0;
                  rx_dphy_rstn_q <= 1'b1;
                  tmr            <= STEP_LOAD;
               end else tmr <= tmr - TMR_ONE;
            end
            FAIL: begin
`ifdef MIPI_LINK_SEQ_ULPS_EN
               if (bus.retry_req) begin
                  state_q      <= ULPS_EXIT;
                  link_fail_q  <= 1'b0;
                  ulps_enter_q <= '0;
                  ulps_exit_q  <= 4'hF;
                  tmr          <= STEP_LOAD;
               end
`endif
            end
            ULPS_EXIT: tmr <= tmr - TMR_ONE;
            default:   state_q <= RST_HOLD;
         endcase
      end
   end

   assign bus.rx_dphy_rstn = rx_dphy_rstn_q;
   assign bus.rx_rstn      = rx_rstn_q;
   assign bus.tx_dphy_rstn = tx_dphy_rstn_q;
   assign bus.tx_rstn      = tx_rstn_q;
   assign bus.rx_clear     = rx_clear_q;
   assign bus.link_up      = link_up_q;
   assign bus.link_fail    = link_fail_q;
   assign bus.retry_cnt    = retry_q;
   assign bus.frame_cnt    = frame_q;
   assign bus.state        = state_q;
`ifdef MIPI_LINK_SEQ_ULPS_EN
   assign bus.tx_ulps_enter = ulps_enter_q;
   assign bus.tx_ulps_exit  = ulps_exit_q;
`else
   assign bus.tx_ulps_enter = 4'h0;
   assign bus.tx_ulps_exit  = 4'h0;
`endif
endmodule

// File: tb/tb_mipi_link_seq.sv
// Directed bench for mipi_link_seq: bring-up timing, frame counting, watchdog recovery,
// retry exhaustion, restart requests and async reset. Follows MIPI_LINK_SEQ_ULPS_EN if defined.
module tb_mipi_link_seq;
   localparam int unsigned RST_CYCLES   = 8;
   localparam int unsigned CLEAR_CYCLES = 16;
   localparam int unsigned WDT_CYCLES   = 100;
   localparam int unsigned MAX_RETRY    = 2;
   localparam int SYNC_LAT = 2;   // edges from i_arstn release until the FSM runs

   localparam logic [2:0] S_RST_HOLD = 3'd0, S_TX_UP = 3'd1, S_RX_UP = 3'd2, S_WAIT_SOF = 3'd3,
                          S_LINK = 3'd4, S_RECOVER = 3'd5, S_FAIL = 3'd6, S_ULPS_EXIT = 3'd7;

   logic sys_clk = 1'b0;
   logic i_arstn;
   int   n_checks = 0;
   int   n_fail   = 0;

   mipi_link_seq_if bus ();

   mipi_link_seq #(
      .RST_CYCLES  (RST_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .WDT_CYCLES  (WDT_CYCLES),
      .MAX_RETRY   (MAX_RETRY)
   ) dut (
      .sys_clk(sys_clk),
      .i_arstn(i_arstn),
      .bus    (bus)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
      int n = 0;
      while (bus.state !== target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.state), 32'(target));
   endtask

   // Frame start is taken on the 3rd edge after vsync rises; returns 3 edges after that.
   task automatic pulse_vsync();
      bus.rx_vsync = 1'b1;
      repeat (3) tick();
      bus.rx_vsync = 1'b0;
      repeat (3) tick();
   endtask

   task automatic measure_release(output int t_txd, output int t_tx, output int t_rxd,
                                  output int t_rx);
      t_txd = 0; t_tx = 0; t_rxd = 0; t_rx = 0;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (bus.tx_dphy_rstn === 1'b1 && t_txd == 0) t_txd = n;
         if (bus.tx_rstn      === 1'b1 && t_tx  == 0) t_tx  = n;
         if (bus.rx_dphy_rstn === 1'b1 && t_rxd == 0) t_rxd = n;
         if (bus.rx_rstn      === 1'b1 && t_rx  == 0) t_rx  = n;
      end
   endtask

   function automatic logic [3:0] rstn_vec();
      return {bus.rx_dphy_rstn, bus.rx_rstn, bus.tx_dphy_rstn, bus.tx_rstn};
   endfunction

   initial begin
      int t_txd, t_tx, t_rxd, t_rx, n;
      bus.rx_vsync  = 1'b0;
      bus.rx_err    = 1'b0;
      bus.retry_req = 1'b0;
      i_arstn       = 1'b1;
      #2 i_arstn = 1'b0;
      repeat (4) tick();

      chk("rst_state", 32'(bus.state), 32'(S_RST_HOLD));
      chk("rst_rstn",  32'(rstn_vec()), 32'h0);
      chk("rst_flags", 32'({bus.rx_clear, bus.link_up, bus.link_fail}), 32'h0);
      chk("rst_cnts",  32'({bus.retry_cnt, bus.frame_cnt}), 32'h0);
      chk("rst_ulps",  32'({bus.tx_ulps_enter, bus.tx_ulps_exit}), 32'h0);

      // Bring-up: release points at RST_CYCLES, +16, +16 FSM cycles.
      i_arstn = 1'b1;
      measure_release(t_txd, t_tx, t_rxd, t_rx);
      chk("up_tx_dphy", 32'(t_txd), 32'(SYNC_LAT + 8));
      chk("up_tx",      32'(t_tx),  32'(SYNC_LAT + 24));
      chk("up_rx_dphy", 32'(t_rxd), 32'(SYNC_LAT + 24));
      chk("up_rx",      32'(t_rx),  32'(SYNC_LAT + 40));
      chk("up_state",   32'(bus.state), 32'(S_WAIT_SOF));

      // First frame start.
      bus.rx_vsync = 1'b1;
      tick(); tick();
      chk("sof_early", 32'(bus.link_up), 32'h0);
      tick();
      chk("sof_link_up", 32'(bus.link_up), 32'h1);
      chk("sof_frame1",  32'(bus.frame_cnt), 32'd1);
      bus.rx_vsync = 1'b0;
      repeat (3) tick();
      pulse_vsync();
      pulse_vsync();
      chk("frame3",     32'(bus.frame_cnt), 32'd3);
      chk("link_state", 32'(bus.state), 32'(S_LINK));

      // Watchdog expiry: last frame start was 3 edges ago.
      n = 3;
      while (bus.state !== S_RECOVER && n < 200) begin
         tick();
         n++;
      end
      chk("wdt_cycle",    32'(n), 32'(WDT_CYCLES));
      chk("rec_clear",    32'(bus.rx_clear), 32'h1);
      chk("rec_retry",    32'(bus.retry_cnt), 32'd1);
      chk("rec_rstn",     32'(rstn_vec()), 32'b0011);
      chk("rec_link_up",  32'(bus.link_up), 32'h0);
      n = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.rx_clear !== 1'b1) break;
         n++;
      end
      chk("clear_width", 32'(n), 32'(CLEAR_CYCLES));
      chk("rec_to_rx_up", 32'(bus.state), 32'(S_RX_UP));
      chk("rec_rx_dphy", 32'(rstn_vec()), 32'b1011);

      // Clean run of 64 in-LINK frame starts clears retry_cnt.
      wait_state("wait_sof_1", S_WAIT_SOF, 40);
      pulse_vsync();
      for (int i = 0; i < 63; i++) pulse_vsync();
      chk("run63_retry", 32'(bus.retry_cnt), 32'd1);
      pulse_vsync();
      chk("run64_retry", 32'(bus.retry_cnt), 32'd0);
      chk("run64_frame", 32'(bus.frame_cnt), 32'd68);

      // Rx error and vsync rising together: error wins.
      bus.rx_vsync = 1'b1;
      bus.rx_err   = 1'b1;
      repeat (3) tick();
      bus.rx_vsync = 1'b0;
      bus.rx_err   = 1'b0;
      chk("err_state", 32'(bus.state), 32'(S_RECOVER));
      chk("err_frame", 32'(bus.frame_cnt), 32'd68);
      chk("err_retry", 32'(bus.retry_cnt), 32'd1);

      // Frame counter wrap.
      wait_state("wait_sof_2", S_WAIT_SOF, 60);
      force dut.frame_q = 16'hFFFF;
      tick();
      release dut.frame_q;
      chk("frame_preset", 32'(bus.frame_cnt), 32'hFFFF);
      pulse_vsync();
      chk("frame_wrap", 32'(bus.frame_cnt), 32'h0);
      chk("wrap_state", 32'(bus.state), 32'(S_LINK));

      // Retries exhausted: LINK timeout, then WAIT_SOF timeout goes to FAIL.
      wait_state("wait_rec_2", S_RECOVER, 150);
      chk("retry2", 32'(bus.retry_cnt), 32'd2);
      wait_state("wait_sof_3", S_WAIT_SOF, 60);
      bus.retry_req = 1'b1;
      tick();
      bus.retry_req = 1'b0;
      chk("req_ignored", 32'(bus.state), 32'(S_WAIT_SOF));
      wait_state("wait_fail", S_FAIL, 150);
      chk("fail_flag",  32'(bus.link_fail), 32'h1);
      chk("fail_retry", 32'(bus.retry_cnt), 32'd2);
      chk("fail_rstn",  32'(rstn_vec()), 32'b0011);
      chk("fail_clear", 32'(bus.rx_clear), 32'h0);
`ifdef MIPI_LINK_SEQ_ULPS_EN
      chk("fail_ulps", 32'(bus.tx_ulps_enter), 32'hF);
`else
      chk("fail_ulps", 32'(bus.tx_ulps_enter), 32'h0);
`endif
      repeat (5) tick();
      chk("fail_holds", 32'(bus.state), 32'(S_FAIL));

      bus.retry_req = 1'b1;
      tick();
      bus.retry_req = 1'b0;
`ifdef MIPI_LINK_SEQ_ULPS_EN
      chk("ulps_state", 32'(bus.state), 32'(S_ULPS_EXIT));
      chk("ulps_ctl",   32'({bus.tx_ulps_enter, bus.tx_ulps_exit}), 32'h0F);
      chk("ulps_fail",  32'(bus.link_fail), 32'h0);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.tx_ulps_exit !== 4'hF) break;
         n++;
      end
      chk("ulps_width", 32'(n), 32'd16);
`endif
      chk("restart_state", 32'(bus.state), 32'(S_RST_HOLD));
      chk("restart_cnts",  32'({bus.retry_cnt, bus.frame_cnt}), 32'h0);
      chk("restart_rstn",  32'(rstn_vec()), 32'h0);
      chk("restart_fail",  32'(bus.link_fail), 32'h0);

      // Restart request from LINK.
      wait_state("wait_sof_4", S_WAIT_SOF, 80);
      pulse_vsync();
      chk("relink_frame", 32'(bus.frame_cnt), 32'd1);
      bus.retry_req = 1'b1;
      tick();
      bus.retry_req = 1'b0;
      chk("link_req_state", 32'(bus.state), 32'(S_RST_HOLD));
      chk("link_req_cnts",  32'({bus.link_up, bus.frame_cnt}), 32'h0);
      chk("link_req_rstn",  32'(rstn_vec()), 32'h0);

      // Async reset mid-sequence restarts the full hold.
      wait_state("wait_tx_up", S_TX_UP, 20);
      repeat (3) tick();
      i_arstn = 1'b0;
      #1;
      chk("async_state", 32'(bus.state), 32'(S_RST_HOLD));
      chk("async_rstn",  32'(rstn_vec()), 32'h0);
      repeat (2) tick();
      i_arstn = 1'b1;
      measure_release(t_txd, t_tx, t_rxd, t_rx);
      chk("rerun_tx_dphy", 32'(t_txd), 32'(SYNC_LAT + 8));
      chk("rerun_rx",      32'(t_rx),  32'(SYNC_LAT + 40));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
